// File: rtl/dbg_pkg.sv
// rtl/dbg_pkg.sv - shared codes, register map and FSM encoding for the debug command mailbox
package dbg_pkg;

    localparam logic [7:0] DBG_CMD_READ   = 8'd0;
    localparam logic [7:0] DBG_CMD_WRITE  = 8'd1;
    localparam logic [7:0] DBG_CMD_HALT   = 8'd2;
    localparam logic [7:0] DBG_CMD_RESUME = 8'd3;

    localparam logic [1:0] REG_CTRL = 2'd0;
    localparam logic [1:0] REG_ADDR = 2'd1;
    localparam logic [1:0] REG_CMD  = 2'd2;
    localparam logic [1:0] REG_RSP  = 2'd3;

    localparam int CTRL_CMD_FULL     = 0;
    localparam int CTRL_CMD_EMPTY    = 1;
    localparam int CTRL_RSP_NONEMPTY = 2;
    localparam int CTRL_BUSY         = 3;
    localparam int CTRL_CPU_HALTED   = 4;
    localparam int CTRL_OVERFLOW     = 5;
    localparam int CTRL_TIMEOUT      = 6;
    localparam int CTRL_BAD_TYPE     = 7;

    localparam int RSP_W = 32;
    localparam int CMD_W = 40;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } dbg_state_e;

    typedef struct packed {
        logic [23:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  ctype;
    } dbg_cmd_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - flop-based synchronous FIFO with flush, full/empty and level
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      cnt_q;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign level_o = cnt_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A push into a full FIFO is dropped even when a pop frees a slot the same cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/debug_cmd_mailbox.sv
// rtl/debug_cmd_mailbox.sv - Avalon-MM command mailbox feeding the debug bridge (DBG_MAILBOX_AUTOINC_EN: ADDR auto-increment)
module debug_cmd_mailbox
    import dbg_pkg::*;
#(
    parameter int CMD_DEPTH   = 8,
    parameter int RSP_DEPTH   = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  avs_address,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    output logic        cmd_valid,
    output logic [7:0]  cmd_type,
    output logic [23:0] cmd_addr,
    output logic [7:0]  cmd_wdata,
    input  logic [7:0]  cmd_rdata,
    input  logic        cmd_done,
    input  logic        cpu_halted
);

    localparam int CAW = $clog2(CMD_DEPTH);
    localparam int RAW = $clog2(RSP_DEPTH);
    localparam int TW  = $clog2(TIMEOUT_CYC);

    logic wr_ctrl, wr_addr, wr_cmd, rd_rsp, flush;
    logic cmd_full, cmd_empty, cmd_accept, cmd_pop;
    logic rsp_full, rsp_empty, rsp_push, rsp_pop;
    logic [CAW:0] cmd_level;
    logic [RAW:0] rsp_level;
    dbg_cmd_t cmd_head, cmd_in;
    logic [RSP_W-1:0] rsp_head, rsp_in;
    logic [31:0] ctrl_word;
    logic unused_wdata;

    dbg_state_e  state_q, state_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [7:0]  cmd_type_q, cmd_type_d;
    logic [23:0] cmd_addr_q, cmd_addr_d;
    logic [7:0]  cmd_wdata_q, cmd_wdata_d;
    logic [23:0] staging_q, staging_d;
    logic        overflow_q, overflow_d;
    logic        timeout_q, timeout_d;
    logic        bad_type_q, bad_type_d;
    logic [31:0] readdata_q, readdata_d;
    logic        bad_set, tmo_set;

    assign wr_ctrl    = avs_write && (avs_address == REG_CTRL);
    assign wr_addr    = avs_write && (avs_address == REG_ADDR);
    assign wr_cmd     = avs_write && (avs_address == REG_CMD);
    assign rd_rsp     = avs_read  && (avs_address == REG_RSP);
    assign flush      = wr_ctrl && avs_writedata[0];
    assign cmd_accept = wr_cmd && !cmd_full;
    assign rsp_pop    = rd_rsp && !rsp_empty;
    assign unused_wdata = ^avs_writedata[31:24];

    assign cmd_in = '{addr: staging_q, wdata: avs_writedata[15:8], ctype: avs_writedata[7:0]};
    assign rsp_in = {cmd_addr_q, cmd_rdata};

    sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (flush),
        .push_i  (cmd_accept),
        .wdata_i (cmd_in),
        .pop_i   (cmd_pop),
        .rdata_o (cmd_head),
        .full_o  (cmd_full),
        .empty_o (cmd_empty),
        .level_o (cmd_level)
    );

    sync_fifo #(.WIDTH(RSP_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (flush),
        .push_i  (rsp_push),
        .wdata_i (rsp_in),
        .pop_i   (rsp_pop),
        .rdata_o (rsp_head),
        .full_o  (rsp_full),
        .empty_o (rsp_empty),
        .level_o (rsp_level)
    );

    always_comb begin
        state_d     = state_q;
        tmo_cnt_d   = tmo_cnt_q;
        cmd_type_d  = cmd_type_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        cmd_pop     = 1'b0;
        rsp_push    = 1'b0;
        bad_set     = 1'b0;
        tmo_set     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!cmd_empty) begin
                    if (cmd_head.ctype > DBG_CMD_RESUME) begin
                        cmd_pop = 1'b1;
                        bad_set = 1'b1;
                    end else if (!(cmd_head.ctype == DBG_CMD_READ && rsp_full)) begin
                        // A read is only taken once its response is guaranteed a slot.
                        cmd_pop     = 1'b1;
                        cmd_type_d  = cmd_head.ctype;
                        cmd_addr_d  = cmd_head.addr;
                        cmd_wdata_d = cmd_head.wdata;
                        state_d     = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                tmo_cnt_d = '0;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                if (cmd_done) begin
                    rsp_push = (cmd_type_q == DBG_CMD_READ);
                    state_d  = ST_GAP;
                end else if (tmo_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
                    tmo_set = 1'b1;
                    state_d = ST_GAP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        overflow_d = (overflow_q && !(wr_ctrl && avs_writedata[CTRL_OVERFLOW]))
                     || (wr_cmd && cmd_full);
        timeout_d  = (timeout_q && !(wr_ctrl && avs_writedata[CTRL_TIMEOUT])) || tmo_set;
        bad_type_d = (bad_type_q && !(wr_ctrl && avs_writedata[CTRL_BAD_TYPE])) || bad_set;

        staging_d = staging_q;
        if (wr_addr) begin
            staging_d = avs_writedata[23:0];
        end
`ifdef DBG_MAILBOX_AUTOINC_EN
        else if (cmd_accept && (avs_writedata[7:0] == DBG_CMD_READ ||
                                avs_writedata[7:0] == DBG_CMD_WRITE)) begin
            staging_d = staging_q + 24'd1;
        end
`endif
    end

    always_comb begin
        ctrl_word = '0;
        ctrl_word[CTRL_CMD_FULL]     = cmd_full;
        ctrl_word[CTRL_CMD_EMPTY]    = cmd_empty;
        ctrl_word[CTRL_RSP_NONEMPTY] = !rsp_empty;
        ctrl_word[CTRL_BUSY]         = (state_q != ST_IDLE);
        ctrl_word[CTRL_CPU_HALTED]   = cpu_halted;
        ctrl_word[CTRL_OVERFLOW]     = overflow_q;
        ctrl_word[CTRL_TIMEOUT]      = timeout_q;
        ctrl_word[CTRL_BAD_TYPE]     = bad_type_q;
        ctrl_word[15:8]              = 8'(cmd_level);
        ctrl_word[23:16]             = 8'(rsp_level);

        readdata_d = readdata_q;
        if (avs_read) begin
            case (avs_address)
                REG_CTRL: readdata_d = ctrl_word;
                REG_ADDR: readdata_d = {8'h00, staging_q};
                REG_CMD:  readdata_d = '0;
                REG_RSP:  readdata_d = rsp_empty ? '0 : rsp_head;
                default:  readdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tmo_cnt_q   <= '0;
            cmd_type_q  <= '0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            staging_q   <= '0;
            overflow_q  <= 1'b0;
            timeout_q   <= 1'b0;
            bad_type_q  <= 1'b0;
            readdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            tmo_cnt_q   <= tmo_cnt_d;
            cmd_type_q  <= cmd_type_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            staging_q   <= staging_d;
            overflow_q  <= overflow_d;
            timeout_q   <= timeout_d;
            bad_type_q  <= bad_type_d;
            readdata_q  <= readdata_d;
        end
    end

    assign cmd_valid    = (state_q == ST_ISSUE);
    assign cmd_type     = cmd_type_q;
    assign cmd_addr     = cmd_addr_q;
    assign cmd_wdata    = cmd_wdata_q;
    assign avs_readdata = readdata_q;

endmodule

// File: tb/tb_debug_cmd_mailbox.sv
// tb/tb_debug_cmd_mailbox.sv - directed and randomized checks of debug_cmd_mailbox against a queue model
module tb_debug_cmd_mailbox;

    localparam int TO = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  avs_address = '0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic        avs_read = 1'b0;
    logic [31:0] avs_readdata;
    logic        cmd_valid;
    logic [7:0]  cmd_type;
    logic [23:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic [7:0]  cmd_rdata = '0;
    logic        cmd_done = 1'b0;
    logic        cpu_halted = 1'b0;

    debug_cmd_mailbox #(.CMD_DEPTH(8), .RSP_DEPTH(8), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .avs_address(avs_address), .avs_write(avs_write), .avs_writedata(avs_writedata),
        .avs_read(avs_read), .avs_readdata(avs_readdata),
        .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .cmd_rdata(cmd_rdata), .cmd_done(cmd_done), .cpu_halted(cpu_halted)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] bridge_val(input logic [23:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
    endfunction

    typedef struct packed {
        logic [7:0]  t;
        logic [23:0] a;
        logic [7:0]  w;
    } disp_t;

    // Bridge model plus dispatch monitor, both evaluated on the falling edge.
    bit          bridge_en = 1'b1;
    bit          lat_rand = 1'b0;
    bit          fixed_rd = 1'b0;
    logic [7:0]  fixed_val = '0;
    int          lat = 3;
    int          bcnt = -1;
    logic [23:0] b_addr = '0;
    disp_t       obs_q[$];
    int          pulse_cyc[$];
    int          pulses = 0;
    int          clash = 0;

    always @(negedge clk) begin
        if (rst) begin
            bcnt      = -1;
            cmd_done  = 1'b0;
            cmd_rdata = '0;
        end else begin
            if (cmd_valid && cmd_done) clash++;
            if (cmd_valid) begin
                obs_q.push_back('{cmd_type, cmd_addr, cmd_wdata});
                pulse_cyc.push_back(cyc);
                pulses++;
            end
            cmd_done = 1'b0;
            if (bcnt == 0) begin
                cmd_done  = 1'b1;
                cmd_rdata = fixed_rd ? fixed_val : bridge_val(b_addr);
                bcnt      = -1;
            end else if (bcnt > 0) begin
                bcnt--;
            end
            if (cmd_valid && bridge_en) begin
                b_addr = cmd_addr;
                bcnt   = lat_rand ? int'($urandom_range(0, 4)) : lat;
            end
        end
    end

    int last_wr_cyc = 0;

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        last_wr_cyc   = cyc;
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        @(negedge clk);
        avs_write     = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        avs_address = a;
        avs_read    = 1'b1;
        @(negedge clk);
        avs_read    = 1'b0;
        d           = avs_readdata;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_pulses(input int n, input int budget, input string tag);
        int k = 0;
        while (pulses < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(pulses >= n), 32'd1);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    logic [31:0] rv;
    logic [31:0] rsp_exp[$];
    disp_t       exp_d[$];
    int          p, p0, t_issue, nreads;
    bit          any_bad;
    logic [23:0] a;
    logic [7:0]  t, w;

    initial begin
        // Reset state
        idle(3);
        check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rst_cmd_addr", 32'(cmd_addr), 32'd0);
        check("rst_readdata", avs_readdata, 32'd0);
        rst = 1'b0;
        rd(2'd0, rv); check("rst_ctrl", rv, 32'h0000_0002);
        rd(2'd1, rv); check("rst_addr", rv, 32'd0);
        cpu_halted = 1'b1;
        rd(2'd0, rv); check("ctrl_halted", rv, 32'h0000_0012);
        cpu_halted = 1'b0;
        rd(2'd3, rv); check("rsp_empty_read", rv, 32'd0);
        rd(2'd2, rv); check("cmd_reg_read", rv, 32'd0);

        // Single peek
        fixed_rd = 1'b1; fixed_val = 8'hA5; lat = 3;
        wr(2'd1, 32'h0001_2345);
        p = pulses;
        wr(2'd2, 32'h0000_0000);
        wait_pulses(p + 1, 20, "peek_dispatch");
        check("peek_latency", 32'(pulse_cyc[p] - last_wr_cyc), 32'd2);
        idle(15);
        check("peek_one_pulse", 32'(pulses), 32'(p + 1));
        check("peek_addr", 32'(obs_q[p].a), 32'h0001_2345);
        check("peek_type", 32'(obs_q[p].t), 32'd0);
        rd(2'd3, rv); check("peek_rsp", rv, 32'h0123_45A5);
        rd(2'd0, rv); check("peek_ctrl_after", rv, 32'h0000_0002);
        fixed_rd = 1'b0;

        // Overflow with a stalled bridge, then flush and timeout of the in-flight halt
        bridge_en = 1'b0;
        p = pulses;
        wr(2'd2, 32'h0000_0002);
        wait_pulses(p + 1, 20, "stall_dispatch");
        t_issue = pulse_cyc[p];
        for (int i = 0; i < 9; i++) wr(2'd2, 32'h0000_0002);
        rd(2'd0, rv); check("ovf_ctrl", rv, 32'h0000_0829);
        wr(2'd0, 32'h0000_0020);
        rd(2'd0, rv); check("ovf_clear", rv, 32'h0000_0809);
        wr(2'd0, 32'h0000_0001);
        rd(2'd0, rv); check("flush_ctrl", rv, 32'h0000_000A);
        wait_cyc(t_issue + TO - 8);
        rd(2'd0, rv); check("pre_timeout_ctrl", rv, 32'h0000_000A);
        wait_cyc(t_issue + TO + 4);
        rd(2'd0, rv); check("timeout_ctrl", rv, 32'h0000_0042);
        check("flushed_not_sent", 32'(pulses), 32'(p + 1));
        bridge_en = 1'b1;
        wr(2'd0, 32'h0000_0040);
        rd(2'd0, rv); check("timeout_clear", rv, 32'h0000_0002);

        // Bad type
        p = pulses;
        wr(2'd2, 32'h0000_0007);
        idle(10);
        check("bad_no_pulse", 32'(pulses), 32'(p));
        rd(2'd0, rv); check("bad_ctrl", rv, 32'h0000_0082);
        wr(2'd0, 32'h0000_0080);

        // Response FIFO full stalls the next read
        lat = 1;
        p = pulses;
        rsp_exp.delete();
        for (int i = 0; i < 8; i++) begin
            a = 24'($urandom);
            wr(2'd1, {8'h00, a});
            wr(2'd2, 32'h0000_0000);
            rsp_exp.push_back({a, bridge_val(a)});
        end
        wait_pulses(p + 8, 200, "fill_dispatch");
        idle(10);
        rd(2'd0, rv); check("rsp_full_ctrl", rv, 32'h0008_0006);
        a = 24'($urandom);
        wr(2'd1, {8'h00, a});
        wr(2'd2, 32'h0000_0000);
        rsp_exp.push_back({a, bridge_val(a)});
        idle(30);
        check("rsp_full_stall", 32'(pulses), 32'(p + 8));
        rd(2'd0, rv); check("stall_ctrl", rv, 32'h0008_0104);
        rd(2'd3, rv); check("rsp_pop_first", rv, rsp_exp.pop_front());
        wait_pulses(p + 9, 20, "unstall_dispatch");
        idle(8);
        for (int i = 0; i < 8; i++) begin
            rd(2'd3, rv); check($sformatf("rsp_drain_%0d", i), rv, rsp_exp.pop_front());
        end
        rd(2'd0, rv); check("drained_ctrl", rv, 32'h0000_0002);

        // Staging address behaviour across two reads from the top of the space
        p = pulses;
        wr(2'd1, 32'h00FF_FFFF);
        wr(2'd2, 32'h0000_0000);
        wr(2'd2, 32'h0000_0000);
        wait_pulses(p + 2, 40, "inc_dispatch");
        idle(8);
        check("inc_addr0", 32'(obs_q[p].a), 32'h00FF_FFFF);
`ifdef DBG_MAILBOX_AUTOINC_EN
        check("inc_addr1", 32'(obs_q[p + 1].a), 32'h0000_0000);
        rd(2'd1, rv); check("inc_staging", rv, 32'h0000_0001);
`else
        check("inc_addr1", 32'(obs_q[p + 1].a), 32'h00FF_FFFF);
        rd(2'd1, rv); check("inc_staging", rv, 32'h00FF_FFFF);
`endif
        for (int i = 0; i < 2; i++) begin
            rd(2'd3, rv);
            check($sformatf("inc_rsp_%0d", i), rv, {obs_q[p + i].a, bridge_val(obs_q[p + i].a)});
        end

        // Halt then resume with a zero-latency bridge
        lat = 0;
        p = pulses;
        wr(2'd2, 32'h0000_0002);
        wr(2'd2, 32'h0000_0003);
        wait_pulses(p + 2, 40, "hr_dispatch");
        check("hr_type0", 32'(obs_q[p].t), 32'd2);
        check("hr_type1", 32'(obs_q[p + 1].t), 32'd3);
        check("hr_spacing", 32'((pulse_cyc[p + 1] - pulse_cyc[p]) >= 4), 32'd1);
        idle(8);

        // Randomized batches against the queue model
        lat_rand = 1'b1;
        for (int b = 0; b < 6; b++) begin
            exp_d.delete();
            rsp_exp.delete();
            any_bad = 1'b0;
            nreads = 0;
            p0 = pulses;
            for (int j = 0; j < int'($urandom_range(1, 6)); j++) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3: t = 8'd0;
                    4, 5:       t = 8'd1;
                    6:          t = 8'd2;
                    7:          t = 8'd3;
                    default:    t = 8'($urandom_range(4, 255));
                endcase
                a = 24'($urandom);
                w = 8'($urandom);
                wr(2'd1, {8'h00, a});
                wr(2'd2, {16'h0000, w, t});
                if (t <= 8'd3) exp_d.push_back('{t, a, w});
                else any_bad = 1'b1;
                if (t == 8'd0) begin
                    rsp_exp.push_back({a, bridge_val(a)});
                    nreads++;
                end
                idle(int'($urandom_range(0, 3)));
            end
            wait_pulses(p0 + exp_d.size(), 300, $sformatf("rnd%0d_dispatch", b));
            idle(10);
            for (int k = 0; k < exp_d.size(); k++) begin
                check($sformatf("rnd%0d_cmd%0d_addr", b, k), 32'(obs_q[p0 + k].a), 32'(exp_d[k].a));
                check($sformatf("rnd%0d_cmd%0d_tw", b, k),
                      {16'h0, obs_q[p0 + k].t, obs_q[p0 + k].w}, {16'h0, exp_d[k].t, exp_d[k].w});
            end
            rd(2'd0, rv);
            check($sformatf("rnd%0d_ctrl", b), rv,
                  32'h2 | (nreads > 0 ? 32'h4 : 32'h0) | (any_bad ? 32'h80 : 32'h0) | (32'(nreads) << 16));
            for (int k = 0; k < nreads; k++) begin
                rd(2'd3, rv); check($sformatf("rnd%0d_rsp%0d", b, k), rv, rsp_exp.pop_front());
            end
            wr(2'd0, 32'h0000_0080);
        end
        lat_rand = 1'b0;

        // Reset while a read waits on the bridge
        bridge_en = 1'b0;
        p = pulses;
        wr(2'd1, 32'h0000_ABCD);
        wr(2'd2, 32'h0000_0000);
        wait_pulses(p + 1, 20, "rstw_dispatch");
        wr(2'd2, 32'h0000_0002);
        wr(2'd2, 32'h0000_0003);
        idle(2);
        #1 rst = 1'b1;
        #1;
        check("rstw_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rstw_cmd_addr", 32'(cmd_addr), 32'd0);
        check("rstw_readdata", avs_readdata, 32'd0);
        idle(2);
        rst = 1'b0;
        bridge_en = 1'b1;
        rd(2'd0, rv); check("rstw_ctrl", rv, 32'h0000_0002);
        rd(2'd1, rv); check("rstw_addr", rv, 32'd0);
        idle(10);
        check("rstw_no_dispatch", 32'(pulses), 32'(p + 1));
        rd(2'd3, rv); check("rstw_rsp", rv, 32'd0);

        check("valid_done_clash", 32'(clash), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
